// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller beside the decode stage.
// Tracks in-flight register writes with a per-register countdown scoreboard,
// stalls decode on RAW hazards (bubbling ID/EX), and squashes wrong-path
// fetches after a decode-resolved redirect.
// Optional feature macro: FORWARD_EN (bypass network present, shorter latencies).
module hazard_ctrl #(
  parameter int LAT_ALU     = 3,
  parameter int LAT_LOAD    = 4,
  parameter int LOAD_USE    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rf_w_en,
  input  logic        id_is_load,
  input  logic [1:0]  id_pcsel,
  input  logic        ext_stall,
  output logic        issue,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic [15:0] stall_count
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  // Latencies are clamped to the largest configured latency and to the
  // counter range, so a too-narrow CNT_W saturates instead of wrapping.
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int MAX_LAT0 = (LAT_ALU > LAT_LOAD) ? LAT_ALU : LAT_LOAD;
  localparam int MAX_LAT  = (MAX_LAT0 > LOAD_USE) ? MAX_LAT0 : LOAD_USE;
  localparam int LAT_CAP  = (MAX_LAT < CNT_MAX) ? MAX_LAT : CNT_MAX;
`ifdef FORWARD_EN
  localparam int ALU_L = 0;
  localparam int LD_L  = LOAD_USE;
`else
  localparam int ALU_L = LAT_ALU;
  localparam int LD_L  = LAT_LOAD;
`endif
  localparam logic [CNT_W-1:0] ALU_LAT_C = CNT_W'((ALU_L < LAT_CAP) ? ALU_L : LAT_CAP);
  localparam logic [CNT_W-1:0] LD_LAT_C  = CNT_W'((LD_L  < LAT_CAP) ? LD_L  : LAT_CAP);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] busy_q [32];
  logic [CNT_W-1:0] busy_d [32];
  logic [15:0]      stall_count_q, stall_count_d;

  logic             rs1_busy, rs2_busy, hazard, issue_c, bubble_c, flush_c;
  logic [CNT_W-1:0] lat;

  // Hazard detection and issue decision; hazards are ignored while flushing.
  always_comb begin
    rs1_busy = id_rs1_used && (id_rs1_addr != 5'd0) && (busy_q[id_rs1_addr] != '0);
    rs2_busy = id_rs2_used && (id_rs2_addr != 5'd0) && (busy_q[id_rs2_addr] != '0);
    hazard   = id_valid && (rs1_busy || rs2_busy) && (state_q == RUN);
    issue_c  = id_valid && !hazard && !ext_stall && (state_q == RUN);
    bubble_c = hazard && !ext_stall;
    lat      = id_is_load ? LD_LAT_C : ALU_LAT_C;
  end

  // Redirect/flush FSM next-state; a stalled branch never redirects.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flush_c = 1'b0;
    case (state_q)
      RUN: begin
        if (issue_c && (id_pcsel != 2'd0)) begin
          flush_c = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            fcnt_d  = 3'(FLUSH_DEPTH - 1);
          end
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (!ext_stall) begin
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  // Scoreboard countdown; a new write never shortens an older pending one.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      busy_d[i] = busy_q[i];
      if (!ext_stall && (busy_q[i] != '0)) busy_d[i] = busy_q[i] - 1'b1;
    end
    if (issue_c && id_rf_w_en && (id_rd_addr != 5'd0)) begin
      if (busy_d[id_rd_addr] < lat) busy_d[id_rd_addr] = lat;
    end
    busy_d[0] = '0;
  end

  // Saturating count of hazard bubble cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (bubble_c && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  // State registers; reset clears any pending flush and all busy counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      fcnt_q        <= 3'd0;
      stall_count_q <= 16'd0;
      for (int i = 0; i < 32; i++) busy_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      stall_count_q <= stall_count_d;
      for (int i = 0; i < 32; i++) busy_q[i] <= busy_d[i];
    end
  end

  // Outputs are forced low while reset is asserted.
  always_comb begin
    issue       = reset_n && issue_c;
    stall_if    = reset_n && (hazard || ext_stall);
    stall_id    = reset_n && (hazard || ext_stall);
    bubble_ex   = reset_n && bubble_c;
    flush_id    = reset_n && flush_c;
    stall_count = stall_count_q;
  end

endmodule
